// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: opcode constants, opcode
// classes and the sequencer state encoding.
package alu_seq_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   typedef enum logic [1:0] {
      BINARY,
      UNARY,
      WIDE,
      BAD
   } op_class_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_T_A    = 3'd1;
   localparam logic [2:0] ST_T_B    = 3'd2;
   localparam logic [2:0] ST_T_WAIT = 3'd3;
   localparam logic [2:0] ST_T_LO   = 3'd4;
   localparam logic [2:0] ST_T_HI   = 3'd5;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      T_A    = ST_T_A,
      T_B    = ST_T_B,
      T_WAIT = ST_T_WAIT,
      T_LO   = ST_T_LO,
      T_HI   = ST_T_HI
   } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier, shared with the top-level control unit.
module alu_op_decode
   import alu_seq_pkg::*;
#(
   parameter int OP_WIDTH = 5
) (
   input  logic [OP_WIDTH-1:0] opcode,
   output logic                legal,
   output logic                unary,
   output logic                wide,
   output logic                is_div
);

   op_class_t cls;

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      cls = BAD;
      case (opcode)
         OP_WIDTH'(OP_ADD), OP_WIDTH'(OP_SUB), OP_WIDTH'(OP_AND),
         OP_WIDTH'(OP_OR),  OP_WIDTH'(OP_ROR), OP_WIDTH'(OP_ROL),
         OP_WIDTH'(OP_SHR), OP_WIDTH'(OP_SHRA), OP_WIDTH'(OP_SHL): cls = BINARY;
         OP_WIDTH'(OP_NEG), OP_WIDTH'(OP_NOT):                     cls = UNARY;
         OP_WIDTH'(OP_MUL), OP_WIDTH'(OP_DIV):                     cls = WIDE;
         default:                                                  cls = BAD;
      endcase
   end

   assign legal  = (cls != BAD);
   assign unary  = (cls == UNARY);
   assign wide   = (cls == WIDE);
   assign is_div = (opcode == OP_WIDTH'(OP_DIV));

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle strobe sequencer moving operands through Y, the ALU and Z/HI/LO
// for one ALU opcode at a time.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int OP_WIDTH    = 5,
   parameter int DIV_LATENCY = 32
) (
   input  logic                clock,
   input  logic                clear,
   input  logic                start,
   input  logic [OP_WIDTH-1:0] opcode,
   output logic                Ra_out,
   output logic                Rb_out,
   output logic                Yin,
   output logic                Zin,
   output logic [OP_WIDTH-1:0] alu_op,
   output logic                Zlow_out,
   output logic                Zhigh_out,
   output logic                Rz_in,
   output logic                LOin,
   output logic                HIin,
   output logic                busy,
   output logic                done,
   output logic                illegal
);

   localparam int CNT_W = $clog2(DIV_LATENCY) + 1;

   state_t              state, state_nxt;
   logic [OP_WIDTH-1:0] op_reg;
   logic                reg_wide, reg_div;
   logic [CNT_W-1:0]    cnt;
   logic                illegal_q;

   logic dec_legal, dec_unary, dec_wide, dec_div;
   logic accept;

   alu_op_decode #(.OP_WIDTH(OP_WIDTH)) u_decode (
      .opcode (opcode),
      .legal  (dec_legal),
      .unary  (dec_unary),
      .wide   (dec_wide),
      .is_div (dec_div)
   );

   assign accept = (state == IDLE) && start && dec_legal;

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state     <= IDLE;
         op_reg    <= '0;
         reg_wide  <= 1'b0;
         reg_div   <= 1'b0;
         cnt       <= '0;
         illegal_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         illegal_q <= (state == IDLE) && start && !dec_legal;
         if (accept) begin
            op_reg   <= opcode;
            reg_wide <= dec_wide;
            reg_div  <= dec_div;
         end
         if (state == T_B && reg_div)
            cnt <= CNT_W'(DIV_LATENCY - 1);
         else if (state == T_WAIT && cnt != '0)
            cnt <= cnt - CNT_W'(1);
      end
   end

   // Strobes depend only on state and the latched op, so clear blanks them at once.
   always_comb begin
      state_nxt = state;
      Ra_out    = 1'b0;
      Rb_out    = 1'b0;
      Yin       = 1'b0;
      Zin       = 1'b0;
      alu_op    = '0;
      Zlow_out  = 1'b0;
      Zhigh_out = 1'b0;
      Rz_in     = 1'b0;
      LOin      = 1'b0;
      HIin      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = dec_unary ? T_B : T_A;
         end
         T_A: begin
            Ra_out    = 1'b1;
            Yin       = 1'b1;
            state_nxt = T_B;
         end
         T_B: begin
            Rb_out    = 1'b1;
            alu_op    = op_reg;
            Zin       = !reg_div;
            state_nxt = reg_div ? T_WAIT : T_LO;
         end
         T_WAIT: begin
            Rb_out = 1'b1;
            alu_op = op_reg;
            if (cnt == '0) begin
               Zin       = 1'b1;
               state_nxt = T_LO;
            end
         end
         T_LO: begin
            Zlow_out = 1'b1;
            if (reg_wide) begin
               LOin      = 1'b1;
               state_nxt = T_HI;
            end else begin
               Rz_in     = 1'b1;
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         T_HI: begin
            Zhigh_out = 1'b1;
            HIin      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy    = (state != IDLE);
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: each issued op pushes its expected per-cycle strobe
// vectors, which are popped and compared one per cycle at the falling edge.
module tb_alu_op_sequencer;

   localparam int DIV_LAT = 4;

   localparam logic [4:0] C_ADD  = 5'b00011;
   localparam logic [4:0] C_SUB  = 5'b00100;
   localparam logic [4:0] C_AND  = 5'b00101;
   localparam logic [4:0] C_OR   = 5'b00110;
   localparam logic [4:0] C_ROR  = 5'b00111;
   localparam logic [4:0] C_ROL  = 5'b01000;
   localparam logic [4:0] C_SHR  = 5'b01001;
   localparam logic [4:0] C_SHRA = 5'b01010;
   localparam logic [4:0] C_SHL  = 5'b01011;
   localparam logic [4:0] C_MUL  = 5'b01111;
   localparam logic [4:0] C_DIV  = 5'b10000;
   localparam logic [4:0] C_NEG  = 5'b10001;
   localparam logic [4:0] C_NOT  = 5'b10010;

   typedef struct packed {
      logic       ra_out;
      logic       rb_out;
      logic       zlow_out;
      logic       zhigh_out;
      logic       yin;
      logic       zin;
      logic [4:0] alu_op;
      logic       rz_in;
      logic       lo_in;
      logic       hi_in;
      logic       busy;
      logic       done;
      logic       illegal;
   } out_t;

   logic       clock = 1'b0;
   logic       clear;
   logic       start;
   logic [4:0] opcode;
   logic       Ra_out, Rb_out, Yin, Zin, Zlow_out, Zhigh_out;
   logic       Rz_in, LOin, HIin, busy, done, illegal;
   logic [4:0] alu_op;

   int   n_checks = 0;
   int   n_errors = 0;
   out_t sb[$];

   alu_op_sequencer #(.OP_WIDTH(5), .DIV_LATENCY(DIV_LAT)) dut (
      .clock     (clock),
      .clear     (clear),
      .start     (start),
      .opcode    (opcode),
      .Ra_out    (Ra_out),
      .Rb_out    (Rb_out),
      .Yin       (Yin),
      .Zin       (Zin),
      .alu_op    (alu_op),
      .Zlow_out  (Zlow_out),
      .Zhigh_out (Zhigh_out),
      .Rz_in     (Rz_in),
      .LOin      (LOin),
      .HIin      (HIin),
      .busy      (busy),
      .done      (done),
      .illegal   (illegal)
   );

   always #5 clock = ~clock;

   function automatic out_t sample();
      out_t o;
      o.ra_out    = Ra_out;
      o.rb_out    = Rb_out;
      o.zlow_out  = Zlow_out;
      o.zhigh_out = Zhigh_out;
      o.yin       = Yin;
      o.zin       = Zin;
      o.alu_op    = alu_op;
      o.rz_in     = Rz_in;
      o.lo_in     = LOin;
      o.hi_in     = HIin;
      o.busy      = busy;
      o.done      = done;
      o.illegal   = illegal;
      return o;
   endfunction

   task automatic check(input string tag, input logic [16:0] act, input logic [16:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %05h expected %05h", tag, act, exp);
      end
   endtask

   // Expected cycle-by-cycle strobes for one request, ending with the idle bubble.
   function automatic void push_op(input logic [4:0] op);
      out_t e;
      bit   is_unary, is_wide, is_div, is_legal;
      is_unary = (op == C_NEG) || (op == C_NOT);
      is_wide  = (op == C_MUL) || (op == C_DIV);
      is_div   = (op == C_DIV);
      is_legal = is_unary || is_wide || (op inside {C_ADD, C_SUB, C_AND, C_OR,
                 C_ROR, C_ROL, C_SHR, C_SHRA, C_SHL});
      if (!is_legal) begin
         e = '0; e.illegal = 1'b1; sb.push_back(e);
         e = '0; sb.push_back(e);
         return;
      end
      if (!is_unary) begin
         e = '0; e.busy = 1'b1; e.ra_out = 1'b1; e.yin = 1'b1; sb.push_back(e);
      end
      e = '0; e.busy = 1'b1; e.rb_out = 1'b1; e.alu_op = op; e.zin = !is_div;
      sb.push_back(e);
      if (is_div) begin
         for (int i = 0; i < DIV_LAT; i++) begin
            e = '0; e.busy = 1'b1; e.rb_out = 1'b1; e.alu_op = op;
            e.zin = (i == DIV_LAT - 1);
            sb.push_back(e);
         end
      end
      e = '0; e.busy = 1'b1; e.zlow_out = 1'b1;
      if (is_wide) e.lo_in = 1'b1;
      else begin e.rz_in = 1'b1; e.done = 1'b1; end
      sb.push_back(e);
      if (is_wide) begin
         e = '0; e.busy = 1'b1; e.zhigh_out = 1'b1; e.hi_in = 1'b1; e.done = 1'b1;
         sb.push_back(e);
      end
      e = '0; sb.push_back(e);
   endfunction

   // Called at a falling edge; returns at the falling edge of the idle bubble.
   // With noise set, a stray start for ADD is pulsed while the op is busy.
   task automatic run_op(input logic [4:0] op, input bit noise);
      int   k;
      out_t exp_v;
      push_op(op);
      start  = 1'b1;
      opcode = op;
      @(posedge clock);
      k = 0;
      while (sb.size() > 0) begin
         @(negedge clock);
         k++;
         exp_v = sb.pop_front();
         check($sformatf("op%05b_c%0d", op, k), sample(), exp_v);
         start = 1'b0;
         if (noise && k >= 2 && k <= 4 && sb.size() > 2) begin
            start  = 1'b1;
            opcode = C_ADD;
         end
      end
      start = 1'b0;
   endtask

   logic [4:0] legal_ops [13] = '{C_ADD, C_SUB, C_AND, C_OR, C_ROR, C_ROL, C_SHR,
                                  C_SHRA, C_SHL, C_MUL, C_DIV, C_NEG, C_NOT};

   initial begin
      clear  = 1'b1;
      start  = 1'b0;
      opcode = '0;
      @(negedge clock);
      check("reset", sample(), 17'h0);
      clear = 1'b0;

      run_op(C_OR, 1'b0);
      run_op(C_NOT, 1'b0);
      run_op(C_MUL, 1'b0);
      run_op(C_DIV, 1'b1);
      run_op(5'b11111, 1'b0);
      run_op(C_ADD, 1'b0);
      run_op(C_NEG, 1'b0);
      run_op(5'b00000, 1'b0);
      run_op(C_SHL, 1'b0);

      // Clear while the divider is waiting: strobes must vanish before the next edge.
      start  = 1'b1;
      opcode = C_DIV;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      check("wait_busy", {16'h0, busy}, 17'h1);
      check("wait_rb", {16'h0, Rb_out}, 17'h1);
      #2 clear = 1'b1;
      #1 check("clear_async", sample(), 17'h0);
      @(posedge clock);
      @(negedge clock);
      check("clear_hold", sample(), 17'h0);
      clear = 1'b0;
      run_op(C_ADD, 1'b0);

      for (int i = 0; i < 8; i++)
         run_op(legal_ops[$urandom_range(0, 12)], 1'b0);
      run_op(C_SUB, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
